// File: rtl/router_tx_port.sv
// router_tx_port
// Serial packet transmitter for one router input port. Takes a destination
// address and a byte stream and drives the din / frame_n / valid_n protocol
// of the crosspoint router. A packet is: 4 address bits (LSB first), a run of
// padding ones, then 8 data bits per byte (LSB first). Before the address
// goes out, the transmitter can wait until the target output port is free.
// Every output is decoded from registered state, the phase counter and the
// byte shift register, so nothing on the serial side depends combinationally
// on the handshake inputs.

module router_tx_port #(
    parameter int PAD_CYCLES = 5,   // padding cycles between address and data (1..15)
    parameter int BUSY_CHECK = 1    // 1: hold in WAIT while the target port is busy
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic [3:0]  cmd_addr,
    output logic        cmd_ready,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        byte_last,
    output logic        byte_ready,
    input  logic [15:0] busy_n,
    output logic        din,
    output logic        frame_n,
    output logic        valid_n,
    output logic        pkt_done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_ADDR = 3'd2,
        S_PAD  = 3'd3,
        S_DATA = 3'd4,
        S_GAP  = 3'd5
    } state_t;

    // Counter value in the final PAD cycle; that cycle doubles as the first
    // byte-fetch slot.
    localparam logic [3:0] PAD_LAST = 4'(PAD_CYCLES - 1);
    localparam logic [3:0] ADDR_LAST = 4'd3;
    localparam logic [3:0] BIT_LAST  = 4'd7;

    state_t      state;
    state_t      state_next;
    logic [3:0]  addr;        // latched destination port
    logic [3:0]  cnt;         // position within ADDR / PAD / DATA byte
    logic [7:0]  shreg;       // byte being serialised, bit 0 is on din
    logic        last_flag;   // the byte in shreg ends the packet

    logic        cmd_take;
    logic        byte_take;
    logic        port_free;
    logic        bit_last;    // final bit of the byte in shreg
    logic        end_of_pkt;  // final bit of the final byte

    assign cmd_take   = cmd_valid & cmd_ready;
    assign byte_take  = byte_valid & byte_ready;
    assign port_free  = (BUSY_CHECK == 0) || busy_n[addr];
    assign bit_last   = (state == S_DATA) && (cnt == BIT_LAST);
    assign end_of_pkt = bit_last && last_flag;

    // State register; reset drops straight back to IDLE, abandoning any packet.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode. The byte-fetch slots (last PAD cycle, bit 7 of a
    // non-last byte) fall into GAP when no byte is offered.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (cmd_take) state_next = S_WAIT;
            end
            S_WAIT: begin
                if (port_free) state_next = S_ADDR;
            end
            S_ADDR: begin
                if (cnt == ADDR_LAST) state_next = S_PAD;
            end
            S_PAD: begin
                if (cnt == PAD_LAST) state_next = byte_take ? S_DATA : S_GAP;
            end
            S_DATA: begin
                if (end_of_pkt) begin
                    state_next = S_IDLE;
                end else if (bit_last) begin
                    state_next = byte_take ? S_DATA : S_GAP;
                end
            end
            S_GAP: begin
                if (byte_take) state_next = S_DATA;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath: address latch, phase counter and byte shift register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr      <= 4'd0;
            cnt       <= 4'd0;
            shreg     <= 8'd0;
            last_flag <= 1'b0;
        end else begin
            if (cmd_take) begin
                addr <= cmd_addr;
            end

            // Counter restarts on every phase change and at each byte boundary
            // so that each phase always counts from zero.
            if ((state_next != state) || bit_last) begin
                cnt <= 4'd0;
            end else if ((state == S_ADDR) || (state == S_PAD) || (state == S_DATA)) begin
                cnt <= cnt + 4'd1;
            end

            if (byte_take) begin
                shreg     <= byte_data;
                last_flag <= byte_last;
            end else if (state == S_DATA) begin
                shreg <= {1'b0, shreg[7:1]};
            end
        end
    end

    // Output decode. cmd_ready is also masked by reset so nothing is offered
    // while reset is held, even though the state already reads IDLE.
    always_comb begin
        cmd_ready  = 1'b0;
        byte_ready = 1'b0;
        din        = 1'b0;
        frame_n    = 1'b1;
        valid_n    = 1'b1;
        pkt_done   = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = ~reset;
            end
            S_WAIT: begin
                cmd_ready = 1'b0;
            end
            S_ADDR: begin
                frame_n = 1'b0;
                din     = addr[cnt[1:0]];
            end
            S_PAD: begin
                frame_n    = 1'b0;
                din        = 1'b1;
                byte_ready = (cnt == PAD_LAST);
            end
            S_DATA: begin
                valid_n    = 1'b0;
                din        = shreg[0];
                frame_n    = end_of_pkt;
                pkt_done   = end_of_pkt;
                byte_ready = bit_last && !last_flag;
            end
            S_GAP: begin
                frame_n    = 1'b0;
                din        = 1'b1;
                byte_ready = 1'b1;
            end
            default: begin
                cmd_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_router_tx_port.sv
// tb_router_tx_port
// Directed bench for router_tx_port: a per-cycle vector table for the
// single-byte packet plus hand-written sequences for busy hold-off, a
// mid-packet gap, back-to-back commands, reset mid-packet and a
// PAD_CYCLES=1 / BUSY_CHECK=0 variant instance.

module tb_router_tx_port;

    logic        clock = 1'b0;
    logic        reset;

    logic        cmd_valid, cmd_ready;
    logic [3:0]  cmd_addr;
    logic        byte_valid, byte_last, byte_ready;
    logic [7:0]  byte_data;
    logic [15:0] busy_n;
    logic        din, frame_n, valid_n, pkt_done;

    logic        v_cmd_valid, v_cmd_ready;
    logic [3:0]  v_cmd_addr;
    logic        v_byte_valid, v_byte_last, v_byte_ready;
    logic [7:0]  v_byte_data;
    logic [15:0] v_busy_n;
    logic        v_din, v_frame_n, v_valid_n, v_pkt_done;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    router_tx_port u_dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_addr(cmd_addr), .cmd_ready(cmd_ready),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_last(byte_last),
        .byte_ready(byte_ready), .busy_n(busy_n),
        .din(din), .frame_n(frame_n), .valid_n(valid_n), .pkt_done(pkt_done)
    );

    router_tx_port #(.PAD_CYCLES(1), .BUSY_CHECK(0)) u_var (
        .clock(clock), .reset(reset),
        .cmd_valid(v_cmd_valid), .cmd_addr(v_cmd_addr), .cmd_ready(v_cmd_ready),
        .byte_valid(v_byte_valid), .byte_data(v_byte_data), .byte_last(v_byte_last),
        .byte_ready(v_byte_ready), .busy_n(v_busy_n),
        .din(v_din), .frame_n(v_frame_n), .valid_n(v_valid_n), .pkt_done(v_pkt_done)
    );

    typedef struct {
        logic bv;
        logic din;
        logic frame_n;
        logic valid_n;
        logic pkt_done;
        logic byte_ready;
        logic cmd_ready;
    } vec_t;

    vec_t tbl [19];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offer a command to the main DUT until accepted; returns in cycle 0 (WAIT).
    task automatic start_cmd(input logic [3:0] a);
        bit acc;
        acc = 1'b0;
        cmd_valid = 1'b1;
        cmd_addr  = a;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(negedge clock);
            acc = cmd_ready;
            tick();
        end
        cmd_valid = 1'b0;
        check("cmd_accept", 32'(acc), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [16:0] dseq;
        int first_low, first_v, pd_cyc, vlow, flow, gapc, nbits, pd_n, acc_n;
        int a2, p1, hi_run;
        bit seen_data, seen2low, acc, br5;
        logic [15:0] bits;
        logic [3:0]  addr2;
        logic [7:0]  vbits;
        logic        d7;

        reset = 1'b1;
        cmd_valid = 1'b1; cmd_addr = 4'h1;
        byte_valid = 1'b0; byte_data = 8'h00; byte_last = 1'b0;
        busy_n = 16'hFFFF;
        v_cmd_valid = 1'b0; v_cmd_addr = 4'h0;
        v_byte_valid = 1'b0; v_byte_data = 8'h00; v_byte_last = 1'b0;
        v_busy_n = 16'h0000;

        // ---------------- reset state (cmd_valid held high throughout)
        #12;
        check("rst_cmd_ready",  32'(cmd_ready),  32'd0);
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_frame_n",    32'(frame_n),    32'd1);
        check("rst_valid_n",    32'(valid_n),    32'd1);
        check("rst_din",        32'(din),        32'd0);
        check("rst_pkt_done",   32'(pkt_done),   32'd0);
        tick();
        tick();
        check("rst_hold_frame_n", 32'(frame_n), 32'd1);
        cmd_valid = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_frame_n",   32'(frame_n),   32'd1);
        tick();

        // ---------------- single byte, table-driven (cycles 0..18)
        // din over cycles 1..17 = 0,1,0,1 | 1,1,1,1,1 | 0,0,1,1,1,0,1,0 ; bit k-1 = cycle k
        dseq = 17'b01011100111111010;
        for (int k = 0; k < 19; k++) begin
            tbl[k].bv         = (k <= 9);
            tbl[k].din        = (k >= 1 && k <= 17) ? dseq[k-1] : 1'b0;
            tbl[k].frame_n    = !(k >= 1 && k <= 16);
            tbl[k].valid_n    = !(k >= 10 && k <= 17);
            tbl[k].pkt_done   = (k == 17);
            tbl[k].byte_ready = (k == 9);
            tbl[k].cmd_ready  = (k == 18);
        end
        byte_data = 8'h5C; byte_last = 1'b1;
        start_cmd(4'hA);
        for (int k = 0; k < 19; k++) begin
            byte_valid = tbl[k].bv;
            @(negedge clock);
            check($sformatf("c%0d_din", k),        32'(din),        32'(tbl[k].din));
            check($sformatf("c%0d_frame_n", k),    32'(frame_n),    32'(tbl[k].frame_n));
            check($sformatf("c%0d_valid_n", k),    32'(valid_n),    32'(tbl[k].valid_n));
            check($sformatf("c%0d_pkt_done", k),   32'(pkt_done),   32'(tbl[k].pkt_done));
            check($sformatf("c%0d_byte_ready", k), 32'(byte_ready), 32'(tbl[k].byte_ready));
            check($sformatf("c%0d_cmd_ready", k),  32'(cmd_ready),  32'(tbl[k].cmd_ready));
            tick();
        end
        byte_valid = 1'b0;

        // ---------------- busy hold-off: busy_n[3]=0 for edges E1..E6
        busy_n = 16'hFFF7;
        byte_valid = 1'b1; byte_data = 8'h00; byte_last = 1'b1;
        start_cmd(4'h3);
        first_low = -1; first_v = -1; pd_cyc = -1; d7 = 1'b0;
        for (int c = 0; c < 41; c++) begin
            if (c == 6) busy_n = 16'hFFFF;
            if (c == 8) busy_n = 16'hFFF7;   // must be ignored once ADDR has started
            @(negedge clock);
            if (!frame_n && first_low < 0) first_low = c;
            if (!valid_n && first_v < 0) first_v = c;
            if (pkt_done && pd_cyc < 0) pd_cyc = c;
            if (c == 7) d7 = din;
            tick();
        end
        check("busy_addr_start", 32'(first_low), 32'd7);
        check("busy_addr_bit0",  32'(d7),        32'd1);
        check("busy_data_start", 32'(first_v),   32'd16);
        check("busy_pkt_done",   32'(pd_cyc),    32'd23);
        busy_n = 16'hFFFF;
        byte_valid = 1'b0;

        // ---------------- mid-packet gap: 0xFF then 0x01, 3 cycles withheld
        start_cmd(4'h2);
        vlow = 0; flow = 0; gapc = 0; nbits = 0; pd_cyc = -1;
        seen_data = 1'b0; bits = 16'h0;
        for (int c = 0; c < 36; c++) begin
            if (c <= 16) begin
                byte_valid = 1'b1; byte_data = 8'hFF; byte_last = 1'b0;
            end else if (c < 20) begin
                byte_valid = 1'b0;
            end else if (c <= 28) begin
                byte_valid = 1'b1; byte_data = 8'h01; byte_last = 1'b1;
            end else begin
                byte_valid = 1'b0;
            end
            @(negedge clock);
            if (!valid_n) begin
                vlow++;
                seen_data = 1'b1;
                if (nbits < 16) bits[nbits] = din;
                nbits++;
            end
            if (!frame_n) flow++;
            if (seen_data && valid_n && !frame_n) gapc++;
            if (pkt_done && pd_cyc < 0) pd_cyc = c;
            tick();
        end
        check("gap_valid_low", 32'(vlow),   32'd16);
        check("gap_cycles",    32'(gapc),   32'd3);
        check("gap_frame_low", 32'(flow),   32'd27);
        check("gap_data_bits", 32'(bits),   32'h01FF);
        check("gap_pkt_done",  32'(pd_cyc), 32'd28);

        // ---------------- back-to-back: cmd_valid held, addr 5 then 9
        byte_valid = 1'b1; byte_data = 8'h3C; byte_last = 1'b1;
        cmd_valid = 1'b1; cmd_addr = 4'h5;
        acc_n = 0; pd_n = 0; a2 = -1; p1 = -1; hi_run = 0;
        seen2low = 1'b0; addr2 = 4'h0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            if (cmd_valid && cmd_ready) begin
                acc_n++;
                if (acc_n == 2) a2 = c;
            end
            if (pkt_done) begin
                pd_n++;
                if (pd_n == 1) p1 = c;
            end
            if (pd_n >= 1 && !seen2low) begin
                if (frame_n) hi_run++;
                else seen2low = 1'b1;
            end
            if (a2 >= 0 && c >= a2 + 2 && c <= a2 + 5) addr2 = {din, addr2[3:1]};
            tick();
            if (acc_n == 1) cmd_addr = 4'h9;
            if (acc_n >= 2) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        byte_valid = 1'b0;
        check("b2b_accepts",      32'(acc_n),   32'd2);
        check("b2b_pkt_dones",    32'(pd_n),    32'd2);
        check("b2b_first_done",   32'(p1),      32'd18);
        check("b2b_accept_after", 32'(a2 - p1), 32'd1);
        check("b2b_frame_hi_run", 32'(hi_run),  32'd3);
        check("b2b_second_addr",  32'(addr2),   32'h9);

        // ---------------- reset during DATA bit 3 of 0xAA
        byte_data = 8'hAA; byte_last = 1'b1;
        start_cmd(4'h6);
        for (int c = 0; c < 13; c++) begin
            byte_valid = (c == 9);
            tick();
        end
        byte_valid = 1'b0;
        #2;
        check("pre_rst_valid_n", 32'(valid_n), 32'd0);
        check("pre_rst_din",     32'(din),     32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_frame_n",   32'(frame_n),   32'd1);
        check("mid_rst_valid_n",   32'(valid_n),   32'd1);
        check("mid_rst_din",       32'(din),       32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("mid_rst_pkt_done",  32'(pkt_done),  32'd0);
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("after_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        tick();
        pd_n = 0; flow = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clock);
            if (pkt_done) pd_n++;
            if (!frame_n) flow++;
            tick();
        end
        check("after_rst_no_done",  32'(pd_n), 32'd0);
        check("after_rst_no_frame", 32'(flow), 32'd0);

        // ---------------- variant: PAD_CYCLES=1, BUSY_CHECK=0, all ports busy
        v_byte_data = 8'h81; v_byte_last = 1'b1;
        v_cmd_valid = 1'b1; v_cmd_addr = 4'hC;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clock);
            acc = v_cmd_ready;
            tick();
        end
        v_cmd_valid = 1'b0;
        check("var_cmd_accept", 32'(acc), 32'd1);
        first_low = -1; first_v = -1; pd_cyc = -1; nbits = 0;
        vbits = 8'h0; addr2 = 4'h0; br5 = 1'b0;
        for (int c = 0; c < 21; c++) begin
            v_byte_valid = (c == 5);
            @(negedge clock);
            if (!v_frame_n && first_low < 0) first_low = c;
            if (!v_valid_n && first_v < 0) first_v = c;
            if (v_pkt_done && pd_cyc < 0) pd_cyc = c;
            if (c >= 1 && c <= 4) addr2 = {v_din, addr2[3:1]};
            if (c == 5) br5 = v_byte_ready;
            if (!v_valid_n) begin
                if (nbits < 8) vbits[nbits] = v_din;
                nbits++;
            end
            tick();
        end
        v_byte_valid = 1'b0;
        check("var_frame_start", 32'(first_low), 32'd1);
        check("var_addr",        32'(addr2),     32'hC);
        check("var_byte_ready",  32'(br5),       32'd1);
        check("var_data_start",  32'(first_v),   32'd6);
        check("var_data_bits",   32'(vbits),     32'h81);
        check("var_pkt_done",    32'(pd_cyc),    32'd13);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_tx_port.md
# router_tx_port

Serial packet transmitter for one router input port: accepts a destination address and a stream of bytes, and drives the per-port `din` / `frame_n` / `valid_n` serial protocol that the 16x16 crosspoint router receives. Before starting a packet it waits for the target output port to be free, using the router's `busy_n` vector. The bench and the traffic-source wrapper instantiate one per router input port (16 total).

## Interface
Parameters:
- `PAD_CYCLES`, default 5: number of padding cycles between the address and data phases (valid range 1..15).
- `BUSY_CHECK`, default 1: 1 = hold in WAIT while the target port is busy; 0 = start immediately.

Ports:
- `clock`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  packet command available.
- `cmd_addr`  in  4  destination output port.
- `cmd_ready`  out  1  command accepted when `cmd_valid & cmd_ready` at a rising edge.
- `byte_valid`  in  1  payload byte available.
- `byte_data`  in  8  payload byte.
- `byte_last`  in  1  marks the final byte of the packet.
- `byte_ready`  out  1  byte accepted when `byte_valid & byte_ready` at a rising edge.
- `busy_n`  in  16  router port-busy flags, active-low (0 = port busy).
- `din`  out  1  serial data to the router.
- `frame_n`  out  1  active-low packet frame.
- `valid_n`  out  1  active-low data-valid.
- `pkt_done`  out  1  one-cycle pulse that coincides with the final data bit.

## Operation
States: IDLE, WAIT, ADDR, PAD, DATA, GAP. All outputs decode from registered state, counters and shift register.

- **IDLE**
  - Outputs: `cmd_ready`=1, `frame_n`=1, `valid_n`=1, `din`=0.
  - On command acceptance: latch `cmd_addr`, go to WAIT.
- **WAIT**
  - Outputs stay at idle values; `cmd_ready`=0.
  - Go to ADDR when `BUSY_CHECK`==0 or `busy_n[addr]`==1 at the edge. Otherwise stay.
- **ADDR**, 4 cycles
  - `frame_n`=0, `valid_n`=1.
  - `din` = addr[0], addr[1], addr[2], addr[3] (LSB first).
- **PAD**, `PAD_CYCLES` cycles
  - `frame_n`=0, `valid_n`=1, `din`=1.
  - `byte_ready`=1 in the last PAD cycle.
- **DATA**, 8 cycles per byte
  - `frame_n`=0, `valid_n`=0.
  - `din` = shift-register bits, LSB first.
  - In bit 7 of a non-last byte, `byte_ready`=1.
  - In bit 7 of the last byte: `frame_n`=1, `pkt_done`=1, `byte_ready`=0; next state is IDLE.
- **Byte-fetch rule** (last PAD cycle, or bit 7 of a non-last byte)
  - If `byte_valid`: load the byte and its last flag; the next cycle drives bit 0.
  - Otherwise: go to GAP.
- **GAP**
  - `frame_n`=0, `valid_n`=1, `din`=1, `byte_ready`=1.
  - Leave for DATA on the first accepted byte.
- `byte_ready`=0 in all other states; `byte_valid` is ignored there.
- A packet carries at least one byte. Every packet ends on a byte flagged `byte_last`.

## Timing
- Reset values, held for the whole time `reset` is high:
  - state IDLE; `frame_n`=1, `valid_n`=1, `din`=0.
  - `cmd_ready`=0, `byte_ready`=0, `pkt_done`=0.
  - No transfer is accepted while `reset` is high.
- Reset asserted mid-packet: outputs return to idle values immediately (asynchronously). The partial packet is abandoned, and no `pkt_done` is produced.
- Cycle numbering: the command is accepted at edge E0. Cycle k is the cycle following edge Ek.
  - Cycle 0: WAIT.
  - Best case, port free: ADDR in cycles 1–4, PAD in cycles 5..4+`PAD_CYCLES`.
  - First data bit in cycle 5+`PAD_CYCLES`.
- Gapless N-byte packet:
  - `frame_n` low for 4+`PAD_CYCLES`+8N−1 cycles.
  - `valid_n` low for exactly 8N cycles.
- Busy target: each edge with `busy_n[addr]`=0 adds one WAIT cycle. `busy_n` is sampled only in WAIT; changes after ADDR starts are ignored.
- Each GAP cycle adds exactly one cycle. `frame_n` stays low throughout a GAP.
- Packet spacing: after `pkt_done` there is one IDLE cycle plus at least one WAIT cycle. This gives at least 2 cycles with `frame_n`=1 between packets.
- `cmd_valid` arriving during a packet is held off (`cmd_ready`=0) and is not dropped.

## Test plan
- **Single byte, default parameters.** Stimulus: addr 0xA, byte 0x5C with `byte_last`, `busy_n`=16'hFFFF. Required response:
  - `din` over cycles 1–17: 0,1,0,1 | 1,1,1,1,1 | 0,0,1,1,1,0,1,0.
  - `valid_n` low only in cycles 10–17.
  - `frame_n` high only in cycle 17; `pkt_done` pulses in cycle 17.
- **Busy hold-off.** Stimulus: addr 3, `busy_n[3]`=0 for 6 edges, then 1. Required response: ADDR starts in cycle 7; no `frame_n` low before that.
- **Mid-packet gap.** Stimulus: 2-byte packet 0xFF, 0x01; `byte_valid` withheld for 3 cycles after byte 0. Required response: 3 cycles with `valid_n`=1 and `frame_n`=0 between the bytes; total `valid_n`-low count is 16.
- **Back-to-back packets.** Stimulus: `cmd_valid` held high with two commands queued. Required response: second command accepted on the cycle after `pkt_done`; at least 2 cycles with `frame_n`=1 between packets.
- **Reset in DATA bit 3.** Required response: `frame_n`=1, `valid_n`=1, `din`=0 within the same cycle; `cmd_ready`=1 in the first cycle after deassertion; no `pkt_done`.
- **Parameter variant.** Stimulus: `PAD_CYCLES`=1, `BUSY_CHECK`=0, `busy_n`=0. Required response: packet starts regardless of `busy_n`; first data bit in cycle 6.
